// File: rtl/shreg_ctrl.sv
// Command sequencer for the 4-bit universal shift register: optional parallel load, then N shifts.
// Define SHREG_CTRL_ROT_EN to enable rotate feed; otherwise the serial inputs always carry the fill bit.
module shreg_ctrl #(
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             CLRN,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic             CMD_LOAD,
  input  logic [3:0]       CMD_DATA,
  input  logic             CMD_DIR,
  input  logic [CNT_W-1:0] CMD_CNT,
  input  logic             CMD_ROT,
  input  logic             CMD_FILL,
  input  logic             QD,
  input  logic             QA,
  output logic [1:0]       S,
  output logic             DSR,
  output logic             DSL,
  output logic             D,
  output logic             C,
  output logic             B,
  output logic             A,
  output logic             BUSY,
  output logic             SOUT,
  output logic             SOUT_VALID,
  output logic             DONE
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FIN} state_t;

  localparam logic [1:0]       S_HOLD  = 2'b00;
  localparam logic [1:0]       S_RIGHT = 2'b01;
  localparam logic [1:0]       S_LEFT  = 2'b10;
  localparam logic [1:0]       S_LOAD  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt_q;
  logic             dir_q;
  logic             rot_q;
  logic             fill_q;
  logic             cmd_rot_eff;

`ifdef SHREG_CTRL_ROT_EN
  assign cmd_rot_eff = CMD_ROT;
`else
  logic unused_cmd_rot;
  assign unused_cmd_rot = CMD_ROT;
  assign cmd_rot_eff    = 1'b0;
`endif

  function automatic logic [1:0] shift_mode(input logic dir);
    return dir ? S_LEFT : S_RIGHT;
  endfunction

  // NOTE: every sequential assignment is non-blocking so all registers update together at the edge.
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      state      <= IDLE;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      rot_q      <= 1'b0;
      fill_q     <= 1'b0;
      CMD_READY  <= 1'b0;
      S          <= S_HOLD;
      {D, C, B, A} <= 4'b0000;
      BUSY       <= 1'b0;
      SOUT       <= 1'b0;
      SOUT_VALID <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      DONE       <= 1'b0;
      SOUT_VALID <= 1'b0;
      case (state)
        IDLE: begin
          CMD_READY <= 1'b1;
          if (CMD_VALID && CMD_READY) begin
            {D, C, B, A} <= CMD_DATA;
            dir_q     <= CMD_DIR;
            rot_q     <= cmd_rot_eff;
            fill_q    <= CMD_FILL;
            cnt_q     <= CMD_CNT;
            CMD_READY <= 1'b0;
            BUSY      <= 1'b1;
            if (CMD_LOAD) begin
              state <= LOAD;
              S     <= S_LOAD;
            end else if (CMD_CNT != '0) begin
              state <= SHIFT;
              S     <= shift_mode(CMD_DIR);
            end else begin
              state <= FIN;
              S     <= S_HOLD;
              DONE  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (cnt_q != '0) begin
            state <= SHIFT;
            S     <= shift_mode(dir_q);
          end else begin
            state <= FIN;
            S     <= S_HOLD;
            DONE  <= 1'b1;
          end
        end
        SHIFT: begin
          // The register moves on this same edge, so the bit leaving it is captured now.
          SOUT       <= dir_q ? QD : QA;
          SOUT_VALID <= 1'b1;
          cnt_q      <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state <= FIN;
            S     <= S_HOLD;
            DONE  <= 1'b1;
          end
        end
        FIN: begin
          state     <= IDLE;
          BUSY      <= 1'b0;
          CMD_READY <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: defaults first so no path leaves a serial input unassigned (no latch).
  always_comb begin
    DSR = 1'b0;
    DSL = 1'b0;
    if (state == SHIFT) begin
      if (dir_q) DSL = rot_q ? QD : fill_q;
      else       DSR = rot_q ? QA : fill_q;
    end
  end

endmodule

// File: tb/tb_shreg_ctrl.sv
// Scoreboard bench for shreg_ctrl driving a behavioural 4-bit universal shift register.
// Honours SHREG_CTRL_ROT_EN the same way as the design build.
`timescale 1ns/1ps
module tb_shreg_ctrl;
  localparam int CNT_W = 3;

  logic             CLK = 1'b0;
  logic             CLRN = 1'b0;
  logic             CMD_VALID, CMD_READY, CMD_LOAD, CMD_DIR, CMD_ROT, CMD_FILL;
  logic [3:0]       CMD_DATA;
  logic [CNT_W-1:0] CMD_CNT;
  logic             QD, QA, DSR, DSL, D, C, B, A, BUSY, SOUT, SOUT_VALID, DONE;
  logic [1:0]       S;

  shreg_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .CLRN(CLRN), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_LOAD(CMD_LOAD), .CMD_DATA(CMD_DATA), .CMD_DIR(CMD_DIR), .CMD_CNT(CMD_CNT),
    .CMD_ROT(CMD_ROT), .CMD_FILL(CMD_FILL), .QD(QD), .QA(QA), .S(S), .DSR(DSR), .DSL(DSL),
    .D(D), .C(C), .B(B), .A(A), .BUSY(BUSY), .SOUT(SOUT), .SOUT_VALID(SOUT_VALID), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // The downstream universal shift register, sharing CLRN with the sequencer.
  logic [3:0] q;
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) q <= 4'b0000;
    else case (S)
      2'b01:   q <= {DSR, q[3:1]};
      2'b10:   q <= {q[2:0], DSL};
      2'b11:   q <= {D, C, B, A};
      default: q <= q;
    endcase
  end
  assign QD = q[3];
  assign QA = q[0];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         acc;
    int         lat;
    logic [3:0] q;
  } done_t;

  logic [1:0] exp_s_q[$];
  logic       exp_sout_q[$];
  done_t      done_q[$];
  logic [3:0] model_q = 4'b0000;

  // Reference: apply the command's shifts to the expected register contents one step at a time.
  task automatic predict(input logic ld, input logic [3:0] data, input logic dir, input int n,
                         input logic rot, input logic fill, input int acc);
    logic [3:0] r;
    logic       rot_e;
    done_t      d;
`ifdef SHREG_CTRL_ROT_EN
    rot_e = rot;
`else
    rot_e = 1'b0;
`endif
    r = ld ? data : model_q;
    if (ld) exp_s_q.push_back(2'b11);
    for (int i = 0; i < n; i++) begin
      exp_s_q.push_back(dir ? 2'b10 : 2'b01);
      if (dir) begin
        exp_sout_q.push_back(r[3]);
        r = {r[2:0], (rot_e ? r[3] : fill)};
      end else begin
        exp_sout_q.push_back(r[0]);
        r = {(rot_e ? r[0] : fill), r[3:1]};
      end
    end
    exp_s_q.push_back(2'b00);
    model_q = r;
    d.acc = acc;
    d.lat = n + (ld ? 2 : 1);
    d.q   = r;
    done_q.push_back(d);
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectations.
  always @(negedge CLK) begin
    if (CLRN) begin
      if (BUSY) begin
        if (exp_s_q.size() == 0) check("busy_extra", 32'(BUSY), 32'd0);
        else check("s_mode", 32'(S), 32'(exp_s_q.pop_front()));
      end else begin
        check("idle_outputs", 32'({S, DSR, DSL}), 32'd0);
      end
      if (SOUT_VALID) begin
        if (exp_sout_q.size() == 0) check("sout_extra", 32'(SOUT_VALID), 32'd0);
        else check("sout_bit", 32'(SOUT), 32'(exp_sout_q.pop_front()));
      end
      if (DONE) begin
        if (done_q.size() == 0) check("done_extra", 32'(DONE), 32'd0);
        else begin
          done_t d;
          d = done_q.pop_front();
          check("done_latency", 32'(cyc + 1 - d.acc), 32'(d.lat));
          check("final_q", 32'(q), 32'(d.q));
          check("ready_low_at_done", 32'(CMD_READY), 32'd0);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with CMD_VALID still high.
  task automatic send(input logic ld, input logic [3:0] data, input logic dir, input int n,
                      input logic rot, input logic fill, output int acc);
    int waited;
    waited    = 0;
    CMD_LOAD  = ld;
    CMD_DATA  = data;
    CMD_DIR   = dir;
    CMD_CNT   = n[CNT_W-1:0];
    CMD_ROT   = rot;
    CMD_FILL  = fill;
    CMD_VALID = 1'b1;
    while (CMD_READY !== 1'b1 && waited < 64) begin
      @(negedge CLK);
      waited++;
    end
    if (waited >= 64) check("accept_timeout", 32'(CMD_READY), 32'd1);
    acc = cyc + 1;
    predict(ld, data, dir, n, rot, fill, acc);
    @(negedge CLK);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((CMD_READY !== 1'b1 || done_q.size() != 0) && w < 64) begin
      @(negedge CLK);
      w++;
    end
    if (w >= 64) check("idle_timeout", 32'(done_q.size()), 32'd0);
  endtask

  initial begin
    int a1, a2;
    CMD_VALID = 1'b0; CMD_LOAD = 1'b0; CMD_DATA = 4'h0; CMD_DIR = 1'b0;
    CMD_CNT = '0; CMD_ROT = 1'b0; CMD_FILL = 1'b0;

    #2;
    check("reset_outputs", 32'({CMD_READY, S, DSR, DSL, D, C, B, A, BUSY, SOUT, SOUT_VALID, DONE}), 32'd0);
    @(negedge CLK);
    CLRN = 1'b1;
    @(negedge CLK);
    check("ready_after_release", 32'(CMD_READY), 32'd1);

    // Load 1011, right x2, fill 1 -> 1110, SOUT 1,1, DONE latency 4
    send(1'b1, 4'b1011, 1'b0, 2, 1'b0, 1'b1, a1);
    CMD_VALID = 1'b0;
    wait_idle();
    check("q_after_fill_right", 32'(q), 32'(4'b1110));

    // Load 1000, left x1, rotate (fill 0 when rotate is disabled)
    send(1'b1, 4'b1000, 1'b1, 1, 1'b1, 1'b0, a1);
    CMD_VALID = 1'b0;
    wait_idle();
`ifdef SHREG_CTRL_ROT_EN
    check("q_rot_left", 32'(q), 32'(4'b0001));
`else
    check("q_rot_left", 32'(q), 32'(4'b0000));
`endif

    // No load, zero shifts: register untouched, DONE after one cycle
    send(1'b0, 4'b1111, 1'b0, 0, 1'b0, 1'b1, a1);
    CMD_VALID = 1'b0;
    wait_idle();
    check("q_unchanged_cnt0", 32'(q), 32'(model_q));

    // Load 0110, right x7 rotate
    send(1'b1, 4'b0110, 1'b0, 7, 1'b1, 1'b0, a1);
    CMD_VALID = 1'b0;
    wait_idle();
`ifdef SHREG_CTRL_ROT_EN
    check("q_rot_right7", 32'(q), 32'(4'b1100));
`else
    check("q_rot_right7", 32'(q), 32'(4'b0000));
`endif

    // CMD_VALID held through a busy command: the next one waits for CMD_READY
    send(1'b1, 4'b0101, 1'b0, 3, 1'b0, 1'b0, a1);
    send(1'b0, 4'b0000, 1'b1, 2, 1'b0, 1'b1, a2);
    check("held_valid_gap", 32'(a2 - a1), 32'd6);
    CMD_VALID = 1'b0;
    wait_idle();

    // Reset in the middle of a shift sequence
    send(1'b1, 4'b0110, 1'b0, 7, 1'b1, 1'b1, a1);
    CMD_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #2 CLRN = 1'b0;
    #1;
    check("midreset_outputs", 32'({CMD_READY, S, DSR, DSL, D, C, B, A, BUSY, SOUT, SOUT_VALID, DONE}), 32'd0);
    check("midreset_q", 32'(q), 32'd0);
    exp_s_q.delete();
    exp_sout_q.delete();
    done_q.delete();
    model_q = 4'b0000;
    @(negedge CLK);
    CLRN = 1'b1;
    @(negedge CLK);
    check("ready_after_midreset", 32'(CMD_READY), 32'd1);
    check("q_after_midreset", 32'(q), 32'd0);

    // Randomised commands, sometimes back to back with CMD_VALID held high
    for (int k = 0; k < 40; k++) begin
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a1);
      if ($urandom_range(0, 1) == 0) begin
        CMD_VALID = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge CLK);
      end
    end
    CMD_VALID = 1'b0;
    wait_idle();
    repeat (2) @(negedge CLK);
    check("queues_drained", 32'(exp_s_q.size() + exp_sout_q.size() + done_q.size()), 32'd0);
    check("final_model_q", 32'(q), 32'(model_q));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shreg_ctrl.md
# shreg_ctrl

Command sequencer that drives the team's 4-bit universal shift register (mode S[1:0], serial inputs DSR/DSL, parallel inputs D/C/B/A, outputs QD..QA, QD = MSB). It accepts one command per valid/ready handshake: an optional parallel load followed by N left or right shifts, with fill-bit or rotate feed. It sits directly upstream of the register, watches the register's QD/QA outputs for rotation, and emits the shifted-out bit stream.

## Interface
- CNT_W, 3, width of shift count; maximum shifts per command is 2^CNT_W-1.

- CLK  in  1  clock, rising edge.
- CLRN  in  1  reset, asynchronous, active-low.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  block idle, can accept a command.
- CMD_LOAD  in  1  1: parallel-load CMD_DATA before shifting.
- CMD_DATA  in  4  load value {D,C,B,A}.
- CMD_DIR  in  1  0: shift right (S=01), 1: shift left (S=10).
- CMD_CNT  in  CNT_W  number of shift cycles.
- CMD_ROT  in  1  1: rotate; 0: shift in CMD_FILL.
- CMD_FILL  in  1  fill bit when not rotating.
- QD, QA  in  1 each  shift-register MSB/LSB feedback.
- S  out  2  register mode: 00 hold, 01 right, 10 left, 11 load.
- DSR, DSL  out  1 each  serial inputs to register.
- D, C, B, A  out  1 each  parallel load data.
- BUSY  out  1  command in progress (not IDLE).
- SOUT  out  1  last bit shifted out.
- SOUT_VALID  out  1  one-cycle strobe qualifying SOUT.
- DONE  out  1  one-cycle strobe at command completion.

## Operation
- States: IDLE, LOAD, SHIFT, FIN.
- IDLE: CMD_READY=1, S=00. On CMD_VALID=1 the command fields (DATA, DIR, CNT, ROT, FILL) are captured. Next state: LOAD if CMD_LOAD=1; else SHIFT if CMD_CNT≠0; else FIN.
- LOAD: one cycle, S=11, {D,C,B,A}=captured data. Next state: SHIFT if CNT≠0, else FIN.
- SHIFT: S=01 or 10 per DIR for exactly CNT cycles. An internal down-counter is loaded with CNT at acceptance and decrements once per SHIFT cycle. The state exits to FIN when the counter reaches 1 during a SHIFT cycle.
- FIN: one cycle, S=00, DONE=1. Next state: IDLE.
- Feed bits are combinational from the captured mode and the QA/QD feedback:
  - Right shift: DSR = ROT ? QA : FILL.
  - Left shift: DSL = ROT ? QD : FILL.
  - The unused serial input is 0.
- Shift-out: in each SHIFT cycle the departing bit (QA for right, QD for left) is registered to SOUT at the closing edge. SOUT_VALID is 1 in the following cycle only.
- D/C/B/A hold the captured data until the next acceptance. DSR/DSL are 0 outside SHIFT.
- CMD_VALID while BUSY is ignored and not queued. CMD_READY=0 in every non-IDLE state.
- CMD_CNT=0 with CMD_LOAD=0: IDLE→FIN→IDLE. Register unchanged, DONE pulses, no SOUT_VALID.

## Timing
- All outputs except DSR/DSL are registered.
- Acceptance at edge k:
  - With load: LOAD occupies cycle k..k+1; shifts occupy the next N cycles; DONE is high N+2 cycles after k.
  - Without load: DONE is high N+1 cycles after k.
  - CMD_READY returns one cycle after DONE.
- The register samples S/D..A/DSR/DSL at the edge ending each state cycle.
- Throughput: at most one command per N+3 cycles with load, or N+2 without.
- Reset values (CLRN=0, immediate, asynchronous): state IDLE, S=00, DSR=DSL=0, D=C=B=A=0, BUSY=0, DONE=0, SOUT=0, SOUT_VALID=0, counter 0, captured fields 0.
- CMD_READY=1 from the first cycle after release.
- Reset mid-command aborts the command with no DONE. The shared CLRN also clears the register.

## Configuration
- SHREG_CTRL_ROT_EN defined: rotate feed as described above.
- Not defined: CMD_ROT is ignored and treated as 0; DSR/DSL always carry FILL during shifts; QD/QA feed only SOUT.

## Test plan
- Load 1011, right, CNT=2, FILL=1, ROT=0 → S sequence 11,01,01,00; Q=1110; SOUT 1,1; DONE 4 cycles after acceptance.
- Load 1000, left, CNT=1, ROT=1 (SHREG_CTRL_ROT_EN) → Q=0001; SOUT=1; without the macro and FILL=0 → Q=0000.
- No load, CNT=0 → DONE one cycle after acceptance; Q unchanged; SOUT_VALID never high.
- Load 0110, right, CNT=7, ROT=1 → Q=1100 (net rotate right by 3); SOUT sequence 0,1,1,0,0,1,1.
- Second CMD_VALID held during SHIFT → ignored; accepted only in the cycle after DONE, when CMD_READY=1.
- CLRN pulsed low mid-SHIFT → all outputs 0 immediately, no DONE, CMD_READY=1 after release, Q=0000.
